// File: rtl/data_memory_pkg.sv
// Shared definitions for the synchronous data memory: FSM states, default
// geometry and the per-byte write merge used by the storage array.
package data_memory_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       enable);
        return enable ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sync_data_memory_if.sv
// Request/response bus of the data memory; the memory is the slave side.
interface sync_data_memory_if
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic                    write_enable;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] byte_enable;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    resp_error;
    logic                    init_done;

    modport master (
        output req_valid, write_enable, address, write_data, byte_enable,
        input  req_ready, resp_valid, read_data, resp_error, init_done
    );

    modport slave (
        input  req_valid, write_enable, address, write_data, byte_enable,
        output req_ready, resp_valid, read_data, resp_error, init_done
    );

endinterface

// File: rtl/data_memory_ram.sv
// Single-port word storage with byte-lane writes and a registered read port.
// Contents are never reset; the owner clears them explicitly.
module data_memory_ram
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0]    be,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // The read register holds its value across writes and idle cycles.
    always_comb begin
        rdata_d = rdata_q;
        wr_word = '0;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
        for (int i = 0; i < BE_W; i++) begin
            wr_word[8*i +: 8] = merge_byte(mem[addr][8*i +: 8], wdata[8*i +: 8], be[i]);
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            mem[addr] <= wr_word;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_data_memory.sv
// Byte-addressed data memory: clears every word after reset, then serves one
// read or write per cycle with a single-cycle response.
module sync_data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_data_memory_if.slave bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_error_q, resp_error_d;
    logic                resp_read_q, resp_read_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  req_err;
    logic                  accept;
    logic                  ram_en;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [BE_W-1:0]       ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        word_idx = bus.address >> OFF_W;
        req_err  = ((bus.address & OFF_MASK) != '0) || (word_idx >= ADDR_WIDTH'(DEPTH));
    end

    // INIT owns the RAM port to zero one word per cycle; READY hands it to the bus.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        accept       = 1'b0;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_read_d  = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = word_idx[IDX_W-1:0];
        ram_be       = bus.byte_enable;
        ram_wdata    = bus.write_data;
        case (state_q)
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_be    = '1;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                accept       = bus.req_valid;
                resp_valid_d = accept;
                resp_error_d = accept && req_err;
                resp_read_d  = accept && !req_err && !bus.write_enable;
                ram_en       = accept && !req_err;
                ram_we       = bus.write_enable;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_read_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_read_q  <= resp_read_d;
        end
    end

    data_memory_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Only read responses expose RAM data; everything else drives zero.
    assign bus.req_ready  = (state_q == ST_READY);
    assign bus.init_done  = (state_q == ST_READY);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.read_data  = resp_read_q ? ram_rdata : '0;

endmodule

// File: tb/tb_sync_data_memory.sv
// Scoreboard bench for sync_data_memory: a reference word array predicts each
// response, which is matched against the DUT one cycle after acceptance.
module tb_sync_data_memory;
    import data_memory_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] addr;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_data_memory #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Response monitor: every pulse must match the oldest prediction on time.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL spurious_resp: read_data=%h resp_error=%b, no response expected",
                         bus.read_data, bus.resp_error);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.read_data !== mon_e.data || bus.resp_error !== mon_e.err || cyc != mon_e.due) begin
                    miscompares++;
                    $display("[TB] FAIL resp@%h: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                             mon_e.addr, bus.read_data, bus.resp_error, cyc, mon_e.data, mon_e.err, mon_e.due);
                end
            end
        end else begin
            vectors++;
            if (bus.read_data !== '0 || bus.resp_error !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_outputs: read_data=%h resp_error=%b, want 0/0",
                         bus.read_data, bus.resp_error);
            end
            if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                miscompares++;
                $display("[TB] FAIL missing_resp@%h: resp_valid=0 at cyc=%0d, want 1",
                         mon_e.addr, cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation still running, want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        logic [7:0] idx;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.write_enable = we;
        bus.address      = addr;
        bus.write_data   = wdata;
        bus.byte_enable  = be;
        idx    = addr[9:2];
        e.err  = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        e.data = '0;
        e.addr = addr;
        e.due  = cyc + 1;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                e.data = model[idx];
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (bus.req_ready !== 1'b1 && cycles < 2000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cycles;
        clear_model();
        @(negedge clk);
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.init_done} !== 4'b0000 || bus.read_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: rdy/vld/err/done=%b%b%b%b data=%h, want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_error, bus.init_done, bus.read_data);
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.init_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_init: req_ready=%b init_done=%b, want 0/0", bus.req_ready, bus.init_done);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cycles);
        vectors++;
        if (cycles !== 256) begin
            miscompares++;
            $display("[TB] FAIL init_length: %0d cycles not ready, want 256", cycles);
        end
        vectors++;
        if (bus.init_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL init_done: %b, want 1", bus.init_done);
        end
        drive_req(1'b0, 32'h0, 32'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_basic_rw();
        drive_req(1'b1, 32'h0, 32'h0000_0001, 4'hF);
        drive_req(1'b1, 32'h4, 32'h0000_0002, 4'hF);
        drive_req(1'b0, 32'h0, 32'h0, 4'h0);
        drive_req(1'b0, 32'h4, 32'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_byte_enable();
        drive_req(1'b1, 32'h8, 32'hAABB_CCDD, 4'b1111);
        drive_req(1'b1, 32'h8, 32'h1122_3344, 4'b0101);
        drive_req(1'b0, 32'h8, 32'h0, 4'h0);
        drive_req(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000);
        drive_req(1'b0, 32'h8, 32'h0, 4'h0);
        drive_req(1'b1, 32'h14, 32'h5566_7788, 4'b1010);
        drive_req(1'b0, 32'h14, 32'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_errors();
        drive_req(1'b0, 32'h2, 32'h0, 4'h0);
        drive_req(1'b0, 32'h400, 32'h0, 4'h0);
        drive_req(1'b1, 32'h9, 32'h1234_5678, 4'hF);
        drive_req(1'b1, 32'h408, 32'h1234_5678, 4'hF);
        drive_req(1'b0, 32'h8, 32'h0, 4'h0);
        drive_req(1'b0, 32'h3FC, 32'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 32'hC, 32'h0000_0005, 4'hF);
        drive_req(1'b0, 32'hC, 32'h0, 4'h0);
        drive_req(1'b1, 32'hC, 32'h0000_A500, 4'b0010);
        drive_req(1'b0, 32'hC, 32'h0, 4'h0);
        idle(2);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = {22'd0, 4'($urandom_range(0, 15)), 4'd0, 2'b00} | 32'({$urandom_range(0, 7)} << 2);
            if ($urandom_range(0, 9) == 0) a = a | 32'h1;
            if ($urandom_range(0, 14) == 0) a = a | 32'h800;
            drive_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) idle(0);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_traffic();
        int cycles;
        drive_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.init_done} !== 4'b0000 || bus.read_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: rdy/vld/err/done=%b%b%b%b data=%h, want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_error, bus.init_done, bus.read_data);
        end
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cycles);
        vectors++;
        if (cycles !== 256) begin
            miscompares++;
            $display("[TB] FAIL reinit_length: %0d cycles not ready, want 256", cycles);
        end
        drive_req(1'b0, 32'h10, 32'h0, 4'h0);
        drive_req(1'b0, 32'h8, 32'h0, 4'h0);
        idle(2);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        bus.byte_enable  = '0;
        test_reset();
        test_basic_rw();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_traffic();
        idle(3);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_responses: %0d outstanding, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_data_memory.md
SYNC_DATA_MEMORY -- requirements
Module: sync_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 256, number of words; SHALL be a power of two.
REQ-003 Parameter ADDR_WIDTH, 32, byte-address width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 write_enable  input  1  1 = write request, 0 = read request.
REQ-010 address  input  ADDR_WIDTH  byte address.
REQ-011 write_data  input  DATA_WIDTH  write data.
REQ-012 byte_enable  input  DATA_WIDTH/8  per-byte write strobe; ignored on reads.
REQ-013 resp_valid  output  1  one-cycle response pulse.
REQ-014 read_data  output  DATA_WIDTH  read result; valid only with resp_valid.
REQ-015 resp_error  output  1  request rejected; valid only with resp_valid.
REQ-016 init_done  output  1  memory clear complete.

Function
REQ-017 FSM states SHALL be INIT and READY; reset enters INIT.
REQ-018 INIT SHALL write zero to word 0, 1, ... DEPTH-1, one word per cycle, with req_ready=0; after DEPTH cycles it SHALL move to READY.
REQ-019 In READY, req_ready SHALL be 1 and init_done SHALL be 1; in INIT both SHALL be 0.
REQ-020 Word index SHALL be address[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low log2(DATA_WIDTH/8) bits are the byte offset.
REQ-021 A request SHALL be in error if the byte offset is nonzero (misaligned) or the word index is >= DEPTH (out of range).
REQ-022 An accepted valid write SHALL update only the bytes whose byte_enable bit is 1; byte_enable=0 SHALL leave the word unchanged and still respond.
REQ-023 An accepted error request SHALL NOT modify memory.
REQ-024 Every accepted request SHALL produce exactly one resp_valid pulse on the following cycle (latency 1).
REQ-025 Read response: read_data = stored word, resp_error=0; write response: read_data=0, resp_error=0; error response: read_data=0, resp_error=1.
REQ-026 Back-to-back requests SHALL be accepted every cycle; there is no response backpressure.
REQ-027 A read accepted the cycle after a write to the same word SHALL return the newly written data.
REQ-028 When resp_valid=0, read_data SHALL be 0 and resp_error SHALL be 0.

Reset
REQ-029 rst_n low SHALL immediately force req_ready=0, resp_valid=0, read_data=0, resp_error=0, init_done=0, state=INIT, clear counter=0.
REQ-030 Reset asserted mid-INIT or mid-traffic SHALL discard any pending response and restart the full memory clear on release.
REQ-031 Memory array contents SHALL NOT be reset directly; zeroing is done only by INIT.

Structure
REQ-032 Shared package data_memory_pkg SHALL hold the FSM state enum, default parameter values and the byte-lane merge function.
REQ-033 Storage SHALL be a sub-module data_memory_ram: single port, byte-enable write, synchronous read, no reset.
REQ-034 sync_data_memory SHALL contain the FSM, clear counter, address decode/error check and response register.

Verification
REQ-035 Reset, release -> req_ready=0 for exactly 256 cycles, then req_ready=1, init_done=1; read of addr 0x0 returns 0x00000000.
REQ-036 Write 0x00000001 to 0x0, write 0x00000002 to 0x4, read 0x0 then 0x4 -> read_data 0x00000001 then 0x00000002, each one cycle after accept.
REQ-037 Write 0xAABBCCDD to 0x8 with byte_enable 4'b1111, then 0x11223344 with 4'b0101 -> read 0x8 returns 0xAA22CC44.
REQ-038 Read 0x2 (misaligned) and 0x400 (index 256) -> resp_error=1, read_data=0; subsequent read shows memory unchanged.
REQ-039 Write 0x5 to 0xC, then read 0xC on the next cycle -> 0x00000005 with no idle cycle.
REQ-040 Assert rst_n low for one cycle after a write to 0x10 is accepted -> no resp_valid, 256-cycle INIT repeats, read 0x10 returns 0x00000000.
